raw_pair_ddr_packer: RTL and testbench

Downstream stage of the dual-camera DVP-to-stream converter, in the `clk_sys` domain. It takes the lock-stepped 8-bit raw pixel pairs (`raw_1`, `raw_2`, `valid_raw`, `sof`, `eof`) and interleaves four pairs into one 64-bit word. Each word carries frame start/end markers and goes out through a valid/ready interface buffered by a small FIFO toward the DDR writer. It also checks line length and sync, and flags words lost when the DDR side back-pressures.

---
 rtl/raw_pack_pkg.sv | 32 +++
 rtl/raw_pack_fifo.sv | 69 ++++++
 rtl/raw_pair_ddr_packer.sv | 191 +++++++++++++++++++
 tb/tb_raw_pair_ddr_packer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raw_pack_pkg.sv
// Shared types and constants for the raw pixel-pair to 64-bit word packer.
package raw_pack_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LINE = 1'b1
  } state_e;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned LANE_W  = 16;
  localparam int unsigned LANES   = 4;
  localparam int unsigned WORD_W  = LANE_W * LANES;
  localparam int unsigned ENTRY_W = WORD_W + 2;

  typedef struct packed {
    logic              eop;
    logic              sop;
    logic [WORD_W-1:0] data;
  } entry_t;

  // Overwrite one 16-bit lane with a camera pair: raw_2 in the upper byte.
  function automatic logic [WORD_W-1:0] put_lane(input logic [WORD_W-1:0] word,
                                                 input logic [1:0]        lane,
                                                 input logic [PIX_W-1:0]  r1,
                                                 input logic [PIX_W-1:0]  r2);
    logic [WORD_W-1:0] w;
    w = word;
    w[LANE_W*32'(lane) +: LANE_W] = {r2, r1};
    return w;
  endfunction

endpackage

// File: rtl/raw_pack_fifo.sv
// Single-clock show-ahead FIFO with registered full/empty flags.
module raw_pack_fifo #(
  parameter int unsigned WIDTH = 66,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push, pop;

  // A write while full is refused even if a read happens in the same cycle.
  always_comb begin
    push     = wr_en & ~full_q;
    pop      = rd_en & ~empty_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    full_d  = (cnt_d == CW'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/raw_pair_ddr_packer.sv
// Packs four lock-stepped camera pixel pairs into 64-bit words with frame markers.
// Optional RAW_PACK_STATS_EN adds drop_cnt and line_cnt_o outputs.
module raw_pair_ddr_packer
  import raw_pack_pkg::*;
#(
  parameter int unsigned PIX_PER_LINE    = 1280,
  parameter int unsigned LINES_PER_FRAME = 720,
  parameter int unsigned FIFO_DEPTH      = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              valid_raw,
  input  logic [PIX_W-1:0]  raw_1,
  input  logic [PIX_W-1:0]  raw_2,
  input  logic              sof,
  input  logic              eof,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sop,
  output logic              m_eop,
  output logic              err_sync,
  output logic              err_len,
  output logic              overflow
`ifdef RAW_PACK_STATS_EN
  ,
  output logic [15:0]       drop_cnt,
  output logic [9:0]        line_cnt_o
`endif
);

  localparam int unsigned PCW = (PIX_PER_LINE > 4) ? $clog2(PIX_PER_LINE) : 3;
  localparam int unsigned LCW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
  localparam logic [PCW-1:0] PIX_LAST  = PCW'(PIX_PER_LINE - 1);
  localparam logic [LCW-1:0] LINE_LAST = LCW'(LINES_PER_FRAME - 1);

  state_e            state_q, state_d;
  logic [PCW-1:0]    pix_cnt_q, pix_cnt_d;
  logic [LCW-1:0]    line_cnt_q, line_cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              push_q, push_d;
  entry_t            entry_q, entry_d;
  logic              err_sync_q, err_sync_d;
  logic              err_len_q, err_len_d;
  logic              overflow_q, overflow_d;
  logic [1:0]        lane;
  logic [WORD_W-1:0] word_first, word_new;
  logic              end_line;
  logic              fifo_full, fifo_empty, drop;
  entry_t            head;

  // Line framing, lane packing and word push decision.
  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    word_d     = word_q;
    push_d     = 1'b0;
    err_sync_d = 1'b0;
    err_len_d  = 1'b0;
    end_line   = 1'b0;
    lane       = pix_cnt_q[1:0];
    word_first = put_lane('0, 2'd0, raw_1, raw_2);
    // Lane 0 starts a fresh word so an early eof leaves the upper lanes zero.
    word_new   = put_lane((lane == 2'd0) ? '0 : word_q, lane, raw_1, raw_2);

    if (frame_start) begin
      state_d    = S_IDLE;
      pix_cnt_d  = '0;
      line_cnt_d = '0;
      word_d     = '0;
    end else if (valid_raw) begin
      case (state_q)
        S_IDLE: begin
          if (sof) begin
            word_d    = word_first;
            pix_cnt_d = PCW'(1);
            state_d   = S_LINE;
          end else begin
            err_sync_d = 1'b1;
          end
        end
        S_LINE: begin
          if (sof) begin
            err_sync_d = 1'b1;
            word_d     = word_first;
            pix_cnt_d  = PCW'(1);
          end else begin
            word_d    = word_new;
            pix_cnt_d = pix_cnt_q + PCW'(1);
            if (eof || (pix_cnt_q == PIX_LAST)) begin
              push_d    = 1'b1;
              end_line  = 1'b1;
              err_len_d = !(eof && (pix_cnt_q == PIX_LAST));
              pix_cnt_d = '0;
              state_d   = S_IDLE;
            end else if (lane == 2'd3) begin
              push_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (end_line && (line_cnt_q != LINE_LAST)) begin
        line_cnt_d = line_cnt_q + LCW'(1);
      end
    end

    entry_d.data = word_new;
    entry_d.sop  = (line_cnt_q == '0) && (pix_cnt_q[PCW-1:2] == '0);
    entry_d.eop  = end_line && (line_cnt_q == LINE_LAST);
  end

  // Sticky drop flag; a frame start re-arms it.
  always_comb begin
    drop       = push_q & fifo_full;
    overflow_d = frame_start ? 1'b0 : (overflow_q | drop);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      word_q     <= '0;
      push_q     <= 1'b0;
      entry_q    <= '0;
      err_sync_q <= 1'b0;
      err_len_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      word_q     <= word_d;
      push_q     <= push_d;
      entry_q    <= entry_d;
      err_sync_q <= err_sync_d;
      err_len_q  <= err_len_d;
      overflow_q <= overflow_d;
    end
  end

  raw_pack_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_sys),
    .rst_n   (reset_n),
    .wr_en   (push_q),
    .wr_data (entry_q),
    .rd_en   (m_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_valid  = ~fifo_empty;
  assign m_data   = head.data;
  assign m_sop    = head.sop;
  assign m_eop    = head.eop;
  assign err_sync = err_sync_q;
  assign err_len  = err_len_q;
  assign overflow = overflow_q;

`ifdef RAW_PACK_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (frame_start) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt   = drop_cnt_q;
  assign line_cnt_o = 10'(line_cnt_q);
`endif

endmodule

// File: tb/tb_raw_pair_ddr_packer.sv
// Directed self-checking bench for raw_pair_ddr_packer (4-line frames to bound run time).
module tb_raw_pair_ddr_packer;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        valid_raw = 1'b0;
  logic [7:0]  raw_1 = '0;
  logic [7:0]  raw_2 = '0;
  logic        sof = 1'b0;
  logic        eof = 1'b0;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_sop;
  logic        m_eop;
  logic        err_sync;
  logic        err_len;
  logic        overflow;
`ifdef RAW_PACK_STATS_EN
  logic [15:0] drop_cnt;
  logic [9:0]  line_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  logic [63:0] q_data[$];
  logic        q_sop[$];
  logic        q_eop[$];
  int          n_sync;
  int          n_len;

  always #5 clk_sys = ~clk_sys;

  raw_pair_ddr_packer #(
    .PIX_PER_LINE    (1280),
    .LINES_PER_FRAME (4),
    .FIFO_DEPTH      (16)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .valid_raw   (valid_raw),
    .raw_1       (raw_1),
    .raw_2       (raw_2),
    .sof         (sof),
    .eof         (eof),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_sop       (m_sop),
    .m_eop       (m_eop),
    .err_sync    (err_sync),
    .err_len     (err_len),
    .overflow    (overflow)
`ifdef RAW_PACK_STATS_EN
    ,
    .drop_cnt    (drop_cnt),
    .line_cnt_o  (line_cnt_o)
`endif
  );

  // Output monitor: record every accepted word and count error pulses.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (m_valid && m_ready) begin
        q_data.push_back(m_data);
        q_sop.push_back(m_sop);
        q_eop.push_back(m_eop);
      end
      if (err_sync) n_sync++;
      if (err_len)  n_len++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Expected word for pixels n0..n0+3 of the nominal pattern raw_1=n, raw_2=~n.
  function automatic logic [63:0] exp_word(input int n0);
    logic [63:0] w;
    logic [7:0]  b;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      b = 8'(n0 + j);
      w[16*j +: 16] = {~b, b};
    end
    return w;
  endfunction

  task automatic drive(input logic v, input logic s, input logic e,
                       input logic [7:0] r1, input logic [7:0] r2);
    @(posedge clk_sys); #1;
    valid_raw = v; sof = s; eof = e; raw_1 = r1; raw_2 = r2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic send_line(input int npix, input int eof_idx);
    logic [7:0] b;
    for (int n = 0; n < npix; n++) begin
      b = 8'(n);
      drive(1'b1, n == 0, n == eof_idx, b, ~b);
    end
  endtask

  task automatic pulse_frame_start();
    @(posedge clk_sys); #1;
    valid_raw = 1'b0; frame_start = 1'b1;
    @(posedge clk_sys); #1;
    frame_start = 1'b0;
  endtask

  task automatic clear_mon();
    q_data.delete(); q_sop.delete(); q_eop.delete();
    n_sync = 0; n_len = 0;
  endtask

  // Bounded wait for n words, then a tail to catch any surplus words.
  task automatic wait_words(input int n);
    int c;
    c = 0;
    while (q_data.size() < n && c < 5000) begin
      @(posedge clk_sys); c++;
    end
    idle(20);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    checks++;
    if ({m_valid, m_sop, m_eop, err_sync, err_len, overflow, m_data} !== '0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%h data=%h required all zero",
               {m_valid, m_sop, m_eop, err_sync, err_len, overflow}, m_data);
    end
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    idle(3);
    @(negedge clk_sys);
    checks++;
    if ({m_valid, err_sync, err_len, overflow} !== 4'b0) begin
      errors++;
      $display("FAIL reset_release: valid/sync/len/ovf=%b required 0000",
               {m_valid, err_sync, err_len, overflow});
    end
  endtask

  task automatic test_nominal();
    logic [7:0] b;
    int bad, nsop, neop;
    m_ready = 1'b1;
    clear_mon();
    for (int n = 0; n < 1280; n++) begin
      b = 8'(n);
      drive(1'b1, n == 0, n == 1279, b, ~b);
      if (n == 4) begin
        checks++;
        if (m_valid !== 1'b0) begin
          errors++; $display("FAIL latency_early: m_valid=%b required 0", m_valid);
        end
      end
      if (n == 5) begin
        checks++;
        if (m_valid !== 1'b1) begin
          errors++; $display("FAIL latency_valid: m_valid=%b required 1", m_valid);
        end
      end
    end
    idle(1);
    wait_words(320);
    checks++;
    if (q_data.size() != 320) begin
      errors++; $display("FAIL nominal_count: got %0d words required 320", q_data.size());
    end
    checks++;
    if (q_data.size() < 1 || q_data[0] !== 64'hFC03_FD02_FE01_FF00 || q_sop[0] !== 1'b1) begin
      errors++;
      $display("FAIL nominal_word0: data=%h sop=%b required FC03FD02FE01FF00 sop=1",
               q_data.size() > 0 ? q_data[0] : 64'h0, q_data.size() > 0 ? q_sop[0] : 1'b0);
    end
    bad = 0; nsop = 0; neop = 0;
    for (int i = 0; i < q_data.size(); i++) begin
      if (q_data[i] !== exp_word(4*i)) bad++;
      if (q_sop[i]) nsop++;
      if (q_eop[i]) neop++;
    end
    checks++;
    if (bad != 0 || nsop != 1 || neop != 0) begin
      errors++;
      $display("FAIL nominal_words: bad=%0d sop=%0d eop=%0d required 0/1/0", bad, nsop, neop);
    end
    checks++;
    if (n_sync != 0 || n_len != 0) begin
      errors++; $display("FAIL nominal_errs: sync=%0d len=%0d required 0/0", n_sync, n_len);
    end
  endtask

  task automatic test_frame();
    int nsop, neop;
    pulse_frame_start();
    clear_mon();
    for (int l = 0; l < 4; l++) send_line(1280, 1279);
    idle(1);
    wait_words(1280);
    checks++;
    if (q_data.size() != 1280) begin
      errors++; $display("FAIL frame_count: got %0d words required 1280", q_data.size());
    end
    nsop = 0; neop = 0;
    foreach (q_sop[i]) if (q_sop[i]) nsop++;
    foreach (q_eop[i]) if (q_eop[i]) neop++;
    checks++;
    if (nsop != 1 || q_sop.size() < 1 || q_sop[0] !== 1'b1) begin
      errors++; $display("FAIL frame_sop: count=%0d required 1 on word 0", nsop);
    end
    checks++;
    if (neop != 1 || q_eop.size() < 1280 || q_eop[1279] !== 1'b1) begin
      errors++; $display("FAIL frame_eop: count=%0d required 1 on word 1279", neop);
    end
    checks++;
    if (n_sync != 0 || n_len != 0) begin
      errors++; $display("FAIL frame_errs: sync=%0d len=%0d required 0/0", n_sync, n_len);
    end
  endtask

  task automatic test_short_line();
    int bad;
    pulse_frame_start();
    clear_mon();
    send_line(1278, 1277);
    idle(1);
    wait_words(320);
    checks++;
    if (q_data.size() != 320) begin
      errors++; $display("FAIL short_count: got %0d words required 320", q_data.size());
    end
    checks++;
    if (q_data.size() < 320 || q_data[319] !== 64'h0000_0000_02FD_03FC) begin
      errors++;
      $display("FAIL short_last: data=%h required 00000000_02FD03FC",
               q_data.size() >= 320 ? q_data[319] : 64'h0);
    end
    bad = 0;
    for (int i = 0; i < 319 && i < q_data.size(); i++) if (q_data[i] !== exp_word(4*i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL short_words: %0d bad words required 0", bad);
    end
    checks++;
    if (n_len != 1 || n_sync != 0) begin
      errors++; $display("FAIL short_errs: len=%0d sync=%0d required 1/0", n_len, n_sync);
    end
  endtask

  task automatic test_sof_restart();
    int bad;
    pulse_frame_start();
    clear_mon();
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 1'b0, 8'hA0 + 8'(i), 8'h50 + 8'(i));
    send_line(1280, 1279);
    idle(1);
    wait_words(321);
    checks++;
    if (q_data.size() != 321) begin
      errors++; $display("FAIL restart_count: got %0d words required 321", q_data.size());
    end
    checks++;
    if (q_data.size() < 2 || q_data[0] !== 64'h53A3_52A2_51A1_50A0
        || q_data[1] !== 64'hFC03_FD02_FE01_FF00) begin
      errors++;
      $display("FAIL restart_head: w0=%h w1=%h required 53A352A251A150A0 FC03FD02FE01FF00",
               q_data.size() > 0 ? q_data[0] : 64'h0, q_data.size() > 1 ? q_data[1] : 64'h0);
    end
    bad = 0;
    for (int i = 1; i < q_data.size(); i++) if (q_data[i] !== exp_word(4*(i-1))) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL restart_words: %0d bad words required 0", bad);
    end
    checks++;
    if (n_sync != 1 || n_len != 0) begin
      errors++; $display("FAIL restart_errs: sync=%0d len=%0d required 1/0", n_sync, n_len);
    end
  endtask

  task automatic test_overrun();
    int bad;
    pulse_frame_start();
    clear_mon();
    send_line(1281, 1280);
    idle(1);
    wait_words(320);
    checks++;
    if (q_data.size() != 320) begin
      errors++; $display("FAIL overrun_count: got %0d words required 320", q_data.size());
    end
    bad = 0;
    foreach (q_data[i]) if (q_data[i] !== exp_word(4*i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL overrun_words: %0d bad words required 0", bad);
    end
    checks++;
    if (n_len != 1 || n_sync != 1) begin
      errors++; $display("FAIL overrun_errs: len=%0d sync=%0d required 1/1", n_len, n_sync);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b;
    int bad;
    pulse_frame_start();
    clear_mon();
    m_ready = 1'b0;
    for (int n = 0; n < 1280; n++) begin
      b = 8'(n);
      drive(1'b1, n == 0, n == 1279, b, ~b);
      if (n == 640) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== exp_word(0)) begin
          errors++;
          $display("FAIL bp_hold_mid: valid=%b data=%h required 1 %h", m_valid, m_data, exp_word(0));
        end
      end
    end
    idle(5);
    @(negedge clk_sys);
    checks++;
    if (m_valid !== 1'b1 || m_data !== exp_word(0) || m_sop !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold_end: valid=%b data=%h sop=%b ovf=%b required 1 %h 1 1",
               m_valid, m_data, m_sop, overflow, exp_word(0));
    end
`ifdef RAW_PACK_STATS_EN
    checks++;
    if (drop_cnt !== 16'd304) begin
      errors++; $display("FAIL bp_drop_cnt: got %0d required 304", drop_cnt);
    end
`endif
    @(posedge clk_sys); #1;
    m_ready = 1'b1;
    wait_words(16);
    checks++;
    if (q_data.size() != 16) begin
      errors++; $display("FAIL bp_count: got %0d words required 16", q_data.size());
    end
    bad = 0;
    foreach (q_data[i]) if (q_data[i] !== exp_word(4*i)) bad++;
    checks++;
    if (bad != 0 || overflow !== 1'b1) begin
      errors++; $display("FAIL bp_words: bad=%0d ovf=%b required 0 1", bad, overflow);
    end
    pulse_frame_start();
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL bp_clear: overflow=%b required 0", overflow);
    end
  endtask

  task automatic test_reset_midline();
    int bad;
    pulse_frame_start();
    clear_mon();
    m_ready = 1'b0;
    send_line(600, -1);
    idle(3);
    checks++;
    if (overflow !== 1'b1 || m_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: ovf=%b valid=%b required 1 1", overflow, m_valid);
    end
    @(posedge clk_sys); #1;
    reset_n = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({m_valid, m_sop, m_eop, err_sync, err_len, overflow, m_data} !== '0) begin
      errors++;
      $display("FAIL midrst_zero: flags=%b data=%h required all zero",
               {m_valid, m_sop, m_eop, err_sync, err_len, overflow}, m_data);
    end
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    m_ready = 1'b1;
    clear_mon();
    send_line(1280, 1279);
    idle(1);
    wait_words(320);
    bad = 0;
    foreach (q_data[i]) if (q_data[i] !== exp_word(4*i)) bad++;
    checks++;
    if (q_data.size() != 320 || bad != 0 || q_sop[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_line: words=%0d bad=%0d required 320 0 with sop on word 0",
               q_data.size(), bad);
    end
    checks++;
    if (n_sync != 0 || n_len != 0) begin
      errors++; $display("FAIL midrst_errs: sync=%0d len=%0d required 0/0", n_sync, n_len);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_frame();
    test_short_line();
    test_sof_restart();
    test_overrun();
    test_backpressure();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
